react_disp: RTL and testbench

REACT_DISP -- requirements
Module: react_disp

---
 rtl/react_pkg.sv | 78 +++++++
 rtl/bin2bcd_seq.sv | 92 +++++++++
 rtl/react_disp.sv | 129 ++++++++++++
 tb/tb_react_disp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/react_pkg.sv
// -----------------------------------------------------------------------------
// react_pkg
// Shared definitions for the reaction-game display slice:
//   - game state codes as driven on react_disp.state
//   - binary-to-BCD converter sequencing states
//   - active-high 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   - width constants and a digit-to-pattern helper
// -----------------------------------------------------------------------------
package react_pkg;

    localparam int STATE_W = 3;
    localparam int RES_W   = 16;
    localparam int BCD_W   = 16;
    localparam int SEG_W   = 8;
    localparam int AN_W    = 4;
    localparam int CNT_W   = 20;

    // Largest value that fits in four decimal digits
    localparam logic [RES_W-1:0] BCD_MAX = 16'd9999;

    // Game state codes; 3'b100 and 3'b101 are unused and display blank
    typedef enum logic [STATE_W-1:0] {
        S0_IDLE   = 3'b000,
        S1_WAIT   = 3'b001,
        S2_FAIL   = 3'b010,
        S3_REACT  = 3'b011,
        S4_RESULT = 3'b111,
        S5_BEST   = 3'b110
    } game_state_e;

    // Sequential converter phases
    typedef enum logic [1:0] {
        CV_IDLE   = 2'd0,
        CV_LOAD   = 2'd1,
        CV_SHIFT  = 2'd2,
        CV_COMMIT = 2'd3
    } conv_state_e;

    // Active-high segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_DIG_0 = 8'h3F;
    localparam logic [SEG_W-1:0] SEG_DIG_1 = 8'h06;
    localparam logic [SEG_W-1:0] SEG_DIG_2 = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_DIG_3 = 8'h4F;
    localparam logic [SEG_W-1:0] SEG_DIG_4 = 8'h66;
    localparam logic [SEG_W-1:0] SEG_DIG_5 = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_DIG_6 = 8'h7D;
    localparam logic [SEG_W-1:0] SEG_DIG_7 = 8'h07;
    localparam logic [SEG_W-1:0] SEG_DIG_8 = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_DIG_9 = 8'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;
    localparam logic [SEG_W-1:0] SEG_BAR   = 8'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 8'h71;
    localparam logic [SEG_W-1:0] SEG_A     = 8'h77;
    localparam logic [SEG_W-1:0] SEG_I     = 8'h06;
    localparam logic [SEG_W-1:0] SEG_L     = 8'h38;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
    localparam logic [SEG_W-1:0] SEG_DP    = 8'h80;

    // Map one BCD nibble to its segment pattern; non-decimal codes are blank
    function automatic logic [SEG_W-1:0] digit_pattern(input logic [3:0] value);
        logic [SEG_W-1:0] pat;
        case (value)
            4'd0:    pat = SEG_DIG_0;
            4'd1:    pat = SEG_DIG_1;
            4'd2:    pat = SEG_DIG_2;
            4'd3:    pat = SEG_DIG_3;
            4'd4:    pat = SEG_DIG_4;
            4'd5:    pat = SEG_DIG_5;
            4'd6:    pat = SEG_DIG_6;
            4'd7:    pat = SEG_DIG_7;
            4'd8:    pat = SEG_DIG_8;
            4'd9:    pat = SEG_DIG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Free-running sequential shift-add-3 binary-to-BCD converter.
// Sequence: IDLE -> LOAD (sample bin, saturate to 9999) -> 16 x SHIFT ->
// COMMIT -> IDLE, i.e. a fresh value is committed every 19 cycles.
// The input is sampled only in LOAD, so changes to bin while shifting do
// not disturb the conversion in flight. bcd changes only at COMMIT, all four
// digits together.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (aborts any conversion)
//   bin    in   16-bit unsigned value
//   bcd    out  4 BCD digits, bcd[15:12] = thousands
//   done   out  one-cycle pulse, high in the cycle after COMMIT updates bcd
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import react_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RES_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    conv_state_e      cv_state_r;
    logic [3:0]       shift_cnt_r;
    logic [RES_W-1:0] bin_sh_r;
    logic [BCD_W-1:0] bcd_work_r;
    logic [BCD_W-1:0] bcd_r;
    logic             done_r;
    logic [BCD_W-1:0] bcd_adj_s;

    // Add 3 to every BCD nibble that is 5 or more before the next shift
    always_comb begin
        bcd_adj_s = bcd_work_r;
        for (int i = 0; i < 4; i++) begin
            if (bcd_work_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_work_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_work_r[4*i +: 4];
            end
        end
    end

    // Converter sequencer, working registers and committed output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_state_r  <= CV_IDLE;
            shift_cnt_r <= 4'd0;
            bin_sh_r    <= 16'd0;
            bcd_work_r  <= 16'd0;
            bcd_r       <= 16'd0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (cv_state_r)
                CV_IDLE: begin
                    cv_state_r <= CV_LOAD;
                end
                CV_LOAD: begin
                    // Saturation here also covers an uninitialised 0xFFFF best
                    bin_sh_r    <= (bin > BCD_MAX) ? BCD_MAX : bin;
                    bcd_work_r  <= 16'd0;
                    shift_cnt_r <= 4'd0;
                    cv_state_r  <= CV_SHIFT;
                end
                CV_SHIFT: begin
                    {bcd_work_r, bin_sh_r} <= {bcd_adj_s, bin_sh_r} << 5'd1;
                    shift_cnt_r            <= shift_cnt_r + 4'd1;
                    if (shift_cnt_r == 4'd15) begin
                        cv_state_r <= CV_COMMIT;
                    end else begin
                        cv_state_r <= CV_SHIFT;
                    end
                end
                CV_COMMIT: begin
                    bcd_r      <= bcd_work_r;
                    done_r     <= 1'b1;
                    cv_state_r <= CV_IDLE;
                end
                default: begin
                    cv_state_r <= CV_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_r;
    assign done = done_r;

endmodule

// File: rtl/react_disp.sv
// -----------------------------------------------------------------------------
// react_disp
// Multiplexed 4-digit 7-segment driver for the reaction game.
// A scan counter holds each digit enabled for SCAN_DIV clocks, cycling
// an[0] -> an[1] -> an[2] -> an[3]. Content is chosen by the registered game
// state: blank, dashes, bars, "FAIL", or the decimal value of result (with the
// decimal point on the leftmost digit for the best-time state).
// seg and an are both loaded from the same digit index in the same cycle, so
// a digit's pattern never appears on a neighbouring enable. Output polarity is
// applied only when loading the output registers.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   state   in   3-bit game state code
//   result  in   16-bit reaction / best time in ms
//   seg     out  {dp,g,f,e,d,c,b,a} for the enabled digit
//   an      out  one-hot digit enable, an[3] leftmost
// -----------------------------------------------------------------------------
module react_disp
    import react_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state,
    input  logic [RES_W-1:0]   result,
    output logic [SEG_W-1:0]   seg,
    output logic [AN_W-1:0]    an
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_FLIP  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [AN_W-1:0]  AN_FLIP   = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

    logic [CNT_W-1:0]   scan_cnt_r;
    logic [1:0]         digit_r;
    logic [STATE_W-1:0] state_r;
    logic [SEG_W-1:0]   seg_r;
    logic [AN_W-1:0]    an_r;

    logic               scan_tc_s;
    logic [BCD_W-1:0]   bcd_s;
    logic               done_unused_s;
    logic [3:0]         nibble_s;
    logic [SEG_W-1:0]   seg_pat_s;
    logic [AN_W-1:0]    an_pat_s;

    // The commit pulse is not needed: bcd_s is already a committed register
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (result),
        .bcd   (bcd_s),
        .done  (done_unused_s)
    );

    assign scan_tc_s = (scan_cnt_r == SCAN_LAST);

    // Scan counter and digit index, advancing on terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= 20'd0;
            digit_r    <= 2'd0;
        end else if (scan_tc_s) begin
            scan_cnt_r <= 20'd0;
            digit_r    <= digit_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + 20'd1;
            digit_r    <= digit_r;
        end
    end

    // Single registration of the game state code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S0_IDLE;
        end else begin
            state_r <= state;
        end
    end

    // Active-high pattern and enable for the current digit index
    always_comb begin
        seg_pat_s = SEG_BLANK;
        an_pat_s  = 4'b0001 << digit_r;
        nibble_s  = bcd_s[{digit_r, 2'b00} +: 4];
        case (state_r)
            S0_IDLE:  seg_pat_s = SEG_BLANK;
            S1_WAIT:  seg_pat_s = SEG_DASH;
            S3_REACT: seg_pat_s = SEG_BAR;
            S2_FAIL: begin
                case (digit_r)
                    2'd3:    seg_pat_s = SEG_F;
                    2'd2:    seg_pat_s = SEG_A;
                    2'd1:    seg_pat_s = SEG_I;
                    2'd0:    seg_pat_s = SEG_L;
                    default: seg_pat_s = SEG_BLANK;
                endcase
            end
            S4_RESULT: seg_pat_s = digit_pattern(nibble_s);
            S5_BEST: begin
                if (digit_r == 2'd3) begin
                    seg_pat_s = digit_pattern(nibble_s) | SEG_DP;
                end else begin
                    seg_pat_s = digit_pattern(nibble_s);
                end
            end
            default: seg_pat_s = SEG_BLANK;
        endcase
    end

    // Output registers; polarity is applied only here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_FLIP;
            an_r  <= AN_FLIP;
        end else begin
            seg_r <= seg_pat_s ^ SEG_FLIP;
            an_r  <= an_pat_s ^ AN_FLIP;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_react_disp.sv
// -----------------------------------------------------------------------------
// tb_react_disp
// Scoreboard bench for react_disp with SCAN_DIV=4 and active-low outputs.
// The stimulus process drives state/result, and for every clock edge after
// reset release pushes the expected {an, seg} derived from the display rules:
// digit k-th edge = ((k-1)/4)%4, content from the state seen one edge
// earlier, value = the decimal digits of min(result, 9999). Right after a
// result change the display may show the old or new value (never a mix)
// until a full re-conversion has surely been committed.
// A separate monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_react_disp;

    localparam int DIV  = 4;
    localparam int SETL = 40;   // edges after a result change until settled
    localparam int FIRST = 19;  // edges from release to the first commit

    logic        clk;
    logic        rst_n;
    logic [2:0]  state;
    logic [15:0] result;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg_a;
        logic [7:0] seg_b;
        bit         alt;
        int         epoch;
        int         kk;
    } exp_t;

    exp_t sbq[$];

    // model state
    int          k;
    logic [2:0]  st_prev;
    int          last_change;
    logic [15:0] last_res;
    int          prev_val;

    react_disp #(
        .SCAN_DIV    (DIV),
        .SEG_ACT_LOW (1),
        .AN_ACT_LOW  (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .state  (state),
        .result (result),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input logic [15:0] r);
        return (r > 16'd9999) ? 9999 : int'(r);
    endfunction

    function automatic logic [7:0] dec_pat(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // expected active-low seg for a display mode, digit position and value
    function automatic logic [7:0] exp_seg(input logic [2:0] st, input int dig, input int val);
        int pw[4];
        logic [7:0] p;
        pw = '{1, 10, 100, 1000};
        p = 8'h00;
        case (st)
            3'b001: p = 8'h40;
            3'b011: p = 8'h06;
            3'b010: begin
                case (dig)
                    3: p = 8'h71;
                    2: p = 8'h77;
                    1: p = 8'h06;
                    default: p = 8'h38;
                endcase
            end
            3'b111: p = dec_pat((val / pw[dig]) % 10);
            3'b110: p = dec_pat((val / pw[dig]) % 10) | ((dig == 3) ? 8'h80 : 8'h00);
            default: p = 8'h00;
        endcase
        return ~p;
    endfunction

    // one clock edge: compute and queue the expected outputs after this edge
    task automatic tick();
        exp_t e;
        int dig;
        @(posedge clk);
        k++;
        if (result != last_res) begin
            prev_val    = (k - 1 < FIRST) ? 0 : sat(last_res);
            last_res    = result;
            last_change = k;
        end
        dig      = ((k - 1) / DIV) % 4;
        e.an     = ~(4'b0001 << dig);
        e.kk     = k;
        e.epoch  = last_change;
        e.alt    = 1'b0;
        if (k - 1 < FIRST) begin
            e.seg_a = exp_seg(st_prev, dig, 0);
            e.seg_b = e.seg_a;
        end else if ((k - 1) - last_change >= SETL) begin
            e.seg_a = exp_seg(st_prev, dig, sat(last_res));
            e.seg_b = e.seg_a;
        end else begin
            e.alt   = 1'b1;
            e.seg_a = exp_seg(st_prev, dig, prev_val);
            e.seg_b = exp_seg(st_prev, dig, sat(last_res));
        end
        st_prev = state;
        sbq.push_back(e);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_out(input string name);
        n_cmp++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL %s an=%b seg=%h required an=1111 seg=ff", name, an, seg);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b1;
        k           = 0;
        st_prev     = 3'b000;
        last_change = 0;
        last_res    = result;
        prev_val    = 0;
    endtask

    task automatic assert_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_out(name);
        repeat (3) @(posedge clk);
        #1;
        check_reset_out({name, "_held"});
    endtask

    // monitor: compare every presented output against the queue head
    initial begin : monitor
        exp_t e;
        int   cur_epoch;
        bit   seen_new;
        bit   ok;
        cur_epoch = -1;
        seen_new  = 1'b0;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                ok = (an === e.an) && ((seg === e.seg_a) || (e.alt && (seg === e.seg_b)));
                if (e.alt) begin
                    if (e.epoch != cur_epoch) begin
                        cur_epoch = e.epoch;
                        seen_new  = 1'b0;
                    end
                    if (seg === e.seg_b && seg !== e.seg_a) begin
                        seen_new = 1'b1;
                    end else if (seg === e.seg_a && seg !== e.seg_b && seen_new) begin
                        ok = 1'b0;
                    end
                end
                if (!ok) begin
                    n_err++;
                    $display("FAIL scan_out k=%0d an=%b seg=%h required an=%b seg=%h alt=%h", e.kk, an, seg, e.an, e.seg_a, e.seg_b);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        rst_n  = 1'b1;
        state  = 3'b000;
        result = 16'd0;
        k = 0; st_prev = 3'b000; last_change = 0; last_res = 16'd0; prev_val = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_out("reset_init");
        release_reset();

        // idle: blank on every digit while the enables rotate
        ticks(32);

        // result display
        state  = 3'b111;
        result = 16'd1234;
        ticks(50);

        // best display, saturated, dp on the leftmost digit
        state  = 3'b110;
        result = 16'hFFFF;
        ticks(50);

        // value change in the middle of a conversion
        state  = 3'b111;
        result = 16'd42;
        ticks(50);
        while (((k - 2) % 19) != 5) tick();
        result = 16'd7000;
        ticks(50);

        // wait / react / fail sequence
        state = 3'b001; ticks(10);
        state = 3'b011; ticks(10);
        state = 3'b010; ticks(20);
        state = 3'b100; ticks(6);
        state = 3'b101; ticks(6);

        // randomized states and results
        for (int it = 0; it < 12; it++) begin
            state = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) result = 16'($urandom);
            else result = 16'($urandom_range(0, 9999));
            for (int j = 0; j < 45; j++) begin
                if ($urandom_range(0, 7) == 0) state = 3'($urandom_range(0, 7));
                tick();
            end
        end

        // reset during a SHIFT phase; display restarts at 0000
        state  = 3'b111;
        result = 16'd5678;
        ticks(45);
        while (((k - 2) % 19) != 8) tick();
        assert_reset("reset_mid_conv");
        release_reset();
        ticks(50);

        @(negedge clk);
        #1;
        n = sbq.size();
        n_cmp++;
        if (n != 0) begin
            n_err++;
            $display("FAIL queue_drain left=%0d required 0", n);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
